// File: rtl/mem_scan_engine.sv
// Memory scan engine: reads `count` words from a synchronous-read memory starting at
// `base_addr` and streams {addr, data, last} over valid/ready. Optional: MEM_SCAN_CHECKSUM_EN.
module mem_scan_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t state, state_n;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   reads_issued;
  logic              inflight;
  logic              inflight_last;
  logic [ADDR_W-1:0] inflight_addr;

  logic [ADDR_W-1:0] fifo_addr [2];
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        occ;

  logic              start_acc;
  logic              push;
  logic              pop;
  logic              last_read;
  logic [1:0]        pending;

  assign mem_addr  = base_q + reads_issued[ADDR_W-1:0];
  assign last_read = (reads_issued == (count_q - ONE));
  assign push      = inflight;
  assign out_addr  = fifo_addr[rd_ptr];
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = fifo_last[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // The slot freed by a same-cycle pop is counted as available, so a steady
  // ready stream sustains one read (and one beat) per cycle.
  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    mem_re    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pop       = 1'b0;
    pending   = occ + {1'b0, inflight};
    case (state)
      IDLE: begin
        if (enable && start) begin
          start_acc = 1'b1;
          state_n   = (count == '0) ? FINISH : SCAN;
        end
      end
      SCAN: begin
        busy      = 1'b1;
        out_valid = enable && (occ != 2'd0);
        pop       = out_valid && out_ready;
        pending   = occ + {1'b0, inflight} - {1'b0, pop};
        mem_re    = enable && (reads_issued < count_q) && (pending < 2'd2);
        if (pop && fifo_last[rd_ptr]) state_n = FINISH;
      end
      FINISH: begin
        done = enable;
        if (enable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Read bookkeeping and the two-entry output buffer. A read already in flight
  // is captured even while enable is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q        <= '0;
      count_q       <= '0;
      reads_issued  <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      inflight_addr <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      occ           <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (start_acc) begin
        base_q       <= base_addr;
        count_q      <= count;
        reads_issued <= '0;
      end else if (mem_re) begin
        reads_issued <= reads_issued + ONE;
      end
      inflight <= mem_re;
      if (mem_re) begin
        inflight_addr <= mem_addr;
        inflight_last <= last_read;
      end
      if (push) begin
        fifo_addr[wr_ptr] <= inflight_addr;
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef MEM_SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clock) begin
    if (reset)          sum_q <= '0;
    else if (start_acc) sum_q <= '0;
    else if (pop)       sum_q <= sum_q + out_data;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_scan_engine.sv
// Testbench for mem_scan_engine: directed and randomized scans compared against an
// address/data list derived from base, count and the memory contents.
module tb_mem_scan_engine;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  always #5 clock = ~clock;

  mem_scan_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .base_addr(base_addr), .count(count),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  always @(posedge clock) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: records handshaken beats and watches the invariants every cycle.
  logic [ADDR_W-1:0] obs_addr [$];
  logic [DATA_W-1:0] obs_data [$];
  logic              obs_last [$];
  int issued = 0, accepted = 0, outst_viol = 0, stab_viol = 0, freeze_viol = 0;
  int done_cnt = 0, done_cyc = 0;
  logic              held_valid = 1'b0;
  logic [ADDR_W-1:0] held_addr;
  logic [DATA_W-1:0] held_data;
  logic              held_last;

  always @(negedge clock) begin
    if (reset) begin
      issued     = 0;
      accepted   = 0;
      held_valid = 1'b0;
    end else begin
      if (issued - accepted > 2) outst_viol++;
      if (held_valid && out_valid &&
          (out_addr !== held_addr || out_data !== held_data || out_last !== held_last))
        stab_viol++;
      if (!enable && (mem_re || out_valid)) freeze_viol++;
      if (mem_re) issued++;
      if (out_valid && out_ready) begin
        accepted++;
        obs_addr.push_back(out_addr);
        obs_data.push_back(out_data);
        obs_last.push_back(out_last);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      held_valid = out_valid && !out_ready;
      held_addr  = out_addr;
      held_data  = out_data;
      held_last  = out_last;
    end
  end

  int ready_mode = 0;
  int rdy_idx    = 0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1:       out_ready = (rdy_idx % 3 == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      rdy_idx++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int scan_start_cyc, q0, d0, i0;

  task automatic start_scan(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n, input string tag);
    @(posedge clock);
    #1;
    start          = 1'b1;
    base_addr      = b;
    count          = n;
    scan_start_cyc = cyc;
    q0             = obs_addr.size();
    d0             = done_cnt;
    i0             = issued;
    @(posedge clock);
    #1;
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    count     = (ADDR_W+1)'($urandom);
    check({tag, ".busy1"}, 32'(busy), 32'(n != 0));
    check({tag, ".re1"}, 32'(mem_re), 32'(n != 0));
    if (n != 0) check({tag, ".addr1"}, 32'(mem_addr), 32'(b));
  endtask

  task automatic finish_scan(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                             input bit chk_lat, input string tag);
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] esum;
    int nb;
    esum = '0;
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    check({tag, ".done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, ".reads"}, 32'(issued - i0), 32'(n));
    nb = obs_addr.size() - q0;
    check({tag, ".beats"}, 32'(nb), 32'(n));
    for (int i = 0; i < int'(n); i++) begin
      ea   = b + ADDR_W'(i);
      esum = esum + mem[ea];
      if (i < nb) begin
        check($sformatf("%s.addr%0d", tag, i), 32'(obs_addr[q0+i]), 32'(ea));
        check($sformatf("%s.data%0d", tag, i), 32'(obs_data[q0+i]), 32'(mem[ea]));
        check($sformatf("%s.last%0d", tag, i), 32'(obs_last[q0+i]), 32'(i == int'(n) - 1));
      end
    end
    if (chk_lat)
      check({tag, ".latency"}, 32'(done_cyc - scan_start_cyc), (n == 0) ? 32'd1 : 32'(n) + 32'd3);
    check({tag, ".outstanding"}, 32'(outst_viol), 32'd0);
    check({tag, ".stable"}, 32'(stab_viol), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
`ifdef MEM_SCAN_CHECKSUM_EN
    check({tag, ".checksum"}, 32'(checksum), 32'(esum));
`else
    check({tag, ".checksum"}, 32'(checksum), 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".mem_re"}, 32'(mem_re), 32'd0);
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_addr"}, 32'(out_addr), 32'd0);
    check({tag, ".out_data"}, 32'(out_data), 32'd0);
    check({tag, ".out_last"}, 32'(out_last), 32'd0);
    check({tag, ".checksum"}, 32'(checksum), 32'd0);
  endtask

  logic [ADDR_W-1:0] rb;
  logic [ADDR_W:0]   rn;
  int                dsnap;

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    mem[8'h10] = 16'h1111;
    mem[8'h11] = 16'h2222;
    mem[8'h12] = 16'h3333;
    mem[8'h13] = 16'h4444;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    ready_mode = 0;
    start_scan(8'h10, 9'd4, "basic");
    finish_scan(8'h10, 9'd4, 1'b1, "basic");
`ifdef MEM_SCAN_CHECKSUM_EN
    check("basic.aaaa", 32'(checksum), 32'h0000AAAA);
`endif

    start_scan(8'hFE, 9'd4, "wrap");
    finish_scan(8'hFE, 9'd4, 1'b1, "wrap");

    ready_mode = 1;
    start_scan(8'h40, 9'd6, "bp");
    finish_scan(8'h40, 9'd6, 1'b0, "bp");

    ready_mode = 2;
    for (int r = 0; r < 4; r++) begin
      rb = ADDR_W'($urandom);
      rn = (ADDR_W+1)'($urandom_range(1, 24));
      start_scan(rb, rn, $sformatf("rand%0d", r));
      finish_scan(rb, rn, 1'b0, $sformatf("rand%0d", r));
    end

    ready_mode = 0;
    start_scan(8'h22, 9'd0, "zero");
    finish_scan(8'h22, 9'd0, 1'b1, "zero");

    start_scan(8'h37, 9'd256, "full");
    finish_scan(8'h37, 9'd256, 1'b1, "full");
    if (obs_addr.size() >= q0 + 256)
      check("full.lastaddr", 32'(obs_addr[q0+255]), 32'h36);

    start_scan(8'h80, 9'd10, "freeze");
    repeat (4) @(posedge clock);
    #1;
    enable = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    enable = 1'b1;
    finish_scan(8'h80, 9'd10, 1'b0, "freeze");
    check("freeze.quiet", 32'(freeze_viol), 32'd0);

    ready_mode = 2;
    start_scan(8'hC0, 9'd8, "abuse");
    for (int k = 0; k < 200 && obs_addr.size() < q0 + 2; k++) @(posedge clock);
    #1;
    start     = 1'b1;
    base_addr = 8'h05;
    count     = 9'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    finish_scan(8'hC0, 9'd8, 1'b0, "abuse");

    ready_mode = 0;
    start_scan(8'h60, 9'd8, "abort");
    for (int k = 0; k < 200 && obs_addr.size() < q0 + 2; k++) @(posedge clock);
    #1;
    reset = 1'b1;
    dsnap = done_cnt;
    @(posedge clock);
    #1;
    check_reset_outputs("abort");
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("abort.no_done", 32'(done_cnt - dsnap), 32'd0);
    check("abort.idle_valid", 32'(out_valid), 32'd0);

    start_scan(8'h61, 9'd5, "recover");
    finish_scan(8'h61, 9'd5, 1'b1, "recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
